div_sign_restore: RTL and testbench

Back end of the signed divider datapath, downstream of the unsigned divider core. It records the quotient and remainder sign bits for each operation the front end issues to the core, in a small in-order tag FIFO. As each unsigned quotient/remainder pair returns from the core, it pops the matching tags, restores the signs in two's complement, and presents the signed result through a registered valid/ready output stage.

---
 rtl/div_sign_restore_if.sv | 29 ++
 rtl/div_sign_restore.sv | 103 ++++++++++
 tb/tb_div_sign_restore.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sign_restore_if.sv
// Handshake bundle between the signed-divider front end, the unsigned core and the
// sign-restore back end: issue tags, core results and the registered signed output.
interface div_sign_restore_if #(
   parameter int WIDTH = 32
);
   logic                    issue_valid;
   logic                    issue_signq;
   logic                    issue_signr;
   logic                    issue_ready;
   logic                    core_valid;
   logic        [WIDTH-1:0] core_q;
   logic        [WIDTH-1:0] core_r;
   logic                    core_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_q;
   logic signed [WIDTH-1:0] out_r;
   logic                    tag_err;

   modport master (
      output issue_valid, issue_signq, issue_signr, core_valid, core_q, core_r, out_ready,
      input  issue_ready, core_ready, out_valid, out_q, out_r, tag_err
   );

   modport slave (
      input  issue_valid, issue_signq, issue_signr, core_valid, core_q, core_r, out_ready,
      output issue_ready, core_ready, out_valid, out_q, out_r, tag_err
   );
endinterface

// File: rtl/div_sign_restore.sv
// Signed-divider back end: in-order sign-tag FIFO plus two's-complement sign restore
// into a registered valid/ready stage. Define DIV_REM_EN to carry the remainder path.
module div_sign_restore #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   div_sign_restore_if.slave bus
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
`ifdef DIV_REM_EN
   localparam int TW = 2;
`else
   localparam int TW = 1;
`endif

   logic [TW-1:0]           tag_mem [DEPTH];
   logic [TW-1:0]           tag_in;
   logic [TW-1:0]           head;
   logic [PW-1:0]           wptr;
   logic [PW-1:0]           rptr;
   logic [PW:0]             count;
   logic                    push;
   logic                    pop;
   logic                    tag_err;
   logic                    vld_p1;
   logic signed [WIDTH-1:0] q_p1;

   function automatic logic signed [WIDTH-1:0] restore_sign(input logic neg,
                                                            input logic [WIDTH-1:0] mag);
      return neg ? $signed(~mag + 1'b1) : $signed(mag);
   endfunction

   // Readies depend only on registered state and out_ready, never on the valids.
   assign bus.issue_ready = !rst && (count != FULL);
   assign bus.core_ready  = !rst && (count != '0) && (!vld_p1 || bus.out_ready);
   assign push            = bus.issue_valid && bus.issue_ready;
   assign pop             = bus.core_valid && bus.core_ready;
   assign head            = tag_mem[rptr];

`ifdef DIV_REM_EN
   assign tag_in = {bus.issue_signq, bus.issue_signr};
`else
   logic unused_rem;
   assign tag_in     = bus.issue_signq;
   assign unused_rem = ^{bus.issue_signr, bus.core_r};
`endif

   always_ff @(posedge clk) begin
      if (push) tag_mem[wptr] <= tag_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         tag_err <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // A result with nothing outstanding is never accepted; just flag it.
         if (bus.core_valid && (count == '0)) tag_err <= 1'b1;
      end
   end

   // ---- stage p1: registered signed result ----
`ifdef DIV_REM_EN
   logic signed [WIDTH-1:0] r_p1;

   always_ff @(posedge clk) begin
      if (rst) r_p1 <= '0;
      else if (pop) r_p1 <= restore_sign(head[0], bus.core_r);
   end

   assign bus.out_r = r_p1;
`else
   assign bus.out_r = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         q_p1   <= '0;
      end else if (pop) begin
         vld_p1 <= 1'b1;
         q_p1   <= restore_sign(head[TW-1], bus.core_q);
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_q     = q_p1;
   assign bus.tag_err   = tag_err;
endmodule

// File: tb/tb_div_sign_restore.sv
// Scoreboard bench for div_sign_restore: directed test-plan cases plus random traffic,
// checked against a queue-based model of the tag FIFO and output register occupancy.
module tb_div_sign_restore;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_sign_restore_if #(.WIDTH(WIDTH)) b();

   div_sign_restore #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [1:0]  tagq [$];
   logic [63:0] expq [$];
   bit          mv   = 1'b0;
   bit          merr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] neg_if(input logic s, input logic [31:0] v);
      return s ? (32'd0 - v) : v;
   endfunction

   function automatic logic [31:0] rem_exp(input logic [31:0] v);
`ifdef DIV_REM_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   // Reference model: tag queue plus output-register occupancy, evaluated mid-cycle.
   always @(negedge clk) begin
      bit          eir, ecr;
      logic [1:0]  t;
      eir = !rst && (tagq.size() != DEPTH);
      ecr = !rst && (tagq.size() != 0) && (!mv || b.out_ready);
      check("issue_ready", 32'(b.issue_ready), 32'(eir));
      check("core_ready", 32'(b.core_ready), 32'(ecr));
      check("out_valid", 32'(b.out_valid), 32'(mv));
      check("tag_err", 32'(b.tag_err), 32'(merr));
      if (rst) begin
         tagq.delete();
         expq.delete();
         mv   = 1'b0;
         merr = 1'b0;
      end else begin
         if (b.core_valid && tagq.size() == 0) merr = 1'b1;
         if (b.core_valid && ecr) begin
            t = tagq.pop_front();
            expq.push_back({neg_if(t[1], b.core_q), rem_exp(neg_if(t[0], b.core_r))});
            mv = 1'b1;
         end else if (b.out_ready) begin
            mv = 1'b0;
         end
         if (b.issue_valid && eir) tagq.push_back({b.issue_signq, b.issue_signr});
      end
   end

   // Monitor: every transferred result is popped from the scoreboard and compared.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && b.out_valid && b.out_ready) begin
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected actual=%h required=none", b.out_q);
         end else begin
            e = expq.pop_front();
            check("sb_out_q", b.out_q, e[63:32]);
            check("sb_out_r", b.out_r, e[31:0]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic sq, input logic sr);
      b.issue_valid = 1'b1;
      b.issue_signq = sq;
      b.issue_signr = sr;
      cyc();
      b.issue_valid = 1'b0;
   endtask

   logic [3:0]  pat;
   logic [31:0] held;

   initial begin
      b.issue_valid = 1'b0;
      b.issue_signq = 1'b0;
      b.issue_signr = 1'b0;
      b.core_valid  = 1'b0;
      b.core_q      = '0;
      b.core_r      = '0;
      b.out_ready   = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rst_issue_ready", 32'(b.issue_ready), 32'd1);
      check("rst_core_ready", 32'(b.core_ready), 32'd0);
      check("rst_out_valid", 32'(b.out_valid), 32'd0);
      check("rst_out_q", b.out_q, 32'd0);
      check("rst_out_r", b.out_r, 32'd0);
      cyc();

      // -15/6 and +3 cases
      issue(1'b1, 1'b1);
      b.core_valid = 1'b1; b.core_q = 32'd2; b.core_r = 32'd3;
      cyc();
      b.core_valid = 1'b0;
      @(negedge clk);
      check("neg_out_valid", 32'(b.out_valid), 32'd1);
      check("neg_out_q", b.out_q, 32'hFFFF_FFFE);
      check("neg_out_r", b.out_r, rem_exp(32'hFFFF_FFFD));
      issue(1'b0, 1'b0);
      b.core_valid = 1'b1; b.core_q = 32'd3; b.core_r = 32'd0;
      cyc();
      b.core_valid = 1'b0;
      @(negedge clk);
      check("pos_out_q", b.out_q, 32'd3);
      check("pos_out_r", b.out_r, 32'd0);
      cyc();

      // Fill the FIFO, try a fifth issue, then drain in order
      pat = 4'b0110;
      for (int i = 0; i < 4; i++) issue(pat[i], 1'b0);
      b.issue_valid = 1'b1;
      @(negedge clk);
      check("full_issue_ready", 32'(b.issue_ready), 32'd0);
      cyc();
      b.issue_valid = 1'b0;
      b.core_q = 32'd1; b.core_r = 32'd0;
      for (int i = 0; i < 4; i++) begin
         b.core_valid = 1'b1;
         cyc();
         @(negedge clk);
         check("fill_out_q", b.out_q, pat[i] ? 32'hFFFF_FFFF : 32'd1);
      end
      b.core_valid = 1'b0;
      cyc();

      // Backpressure then back-to-back
      issue(1'b1, 1'b0);
      issue(1'b0, 1'b1);
      issue(1'b1, 1'b1);
      b.out_ready = 1'b0;
      b.core_valid = 1'b1; b.core_q = 32'd5; b.core_r = 32'd1;
      cyc();
      @(negedge clk);
      held = b.out_q;
      check("bp_first", held, 32'hFFFF_FFFB);
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         check("bp_hold_q", b.out_q, 32'hFFFF_FFFB);
         check("bp_core_ready", 32'(b.core_ready), 32'd0);
      end
      b.out_ready = 1'b1;
      b.core_q = 32'd6;
      cyc();
      @(negedge clk);
      check("b2b_q0", b.out_q, 32'd6);
      cyc();
      @(negedge clk);
      check("b2b_valid", 32'(b.out_valid), 32'd1);
      check("b2b_q1", b.out_q, 32'hFFFF_FFFA);
      b.core_valid = 1'b0;
      cyc();

      // Edge values
      issue(1'b1, 1'b1);
      issue(1'b1, 1'b1);
      b.core_valid = 1'b1; b.core_q = 32'd0; b.core_r = 32'h8000_0000;
      cyc();
      @(negedge clk);
      check("edge_zero", b.out_q, 32'd0);
      check("edge_min_r", b.out_r, rem_exp(32'h8000_0000));
      b.core_q = 32'h8000_0000; b.core_r = 32'd0;
      cyc();
      @(negedge clk);
      check("edge_min", b.out_q, 32'h8000_0000);
      b.core_valid = 1'b0;
      cyc();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         b.issue_valid = ($urandom_range(0, 2) != 0);
         b.issue_signq = 1'($urandom);
         b.issue_signr = 1'($urandom);
         b.core_valid  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       b.core_q = 32'h8000_0000;
            1:       b.core_q = 32'd0;
            default: b.core_q = $urandom;
         endcase
         b.core_r    = $urandom;
         b.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      b.issue_valid = 1'b0;
      b.core_valid  = 1'b0;
      b.out_ready   = 1'b1;
      repeat (4) cyc();

      // Reset with tags outstanding
      issue(1'b1, 1'b0);
      issue(1'b0, 1'b1);
      issue(1'b1, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_issue_ready", 32'(b.issue_ready), 32'd1);
      check("mrst_core_ready", 32'(b.core_ready), 32'd0);
      check("mrst_out_valid", 32'(b.out_valid), 32'd0);
      cyc();
      issue(1'b1, 1'b0);
      b.core_valid = 1'b1; b.core_q = 32'd7; b.core_r = 32'd2;
      cyc();
      b.core_valid = 1'b0;
      @(negedge clk);
      check("mrst_pair_q", b.out_q, 32'hFFFF_FFF9);
      check("mrst_pair_r", b.out_r, rem_exp(32'd2));
      cyc();

      // Orphan result
      b.core_valid = 1'b1; b.core_q = 32'd9;
      repeat (3) cyc();
      b.core_valid = 1'b0;
      @(negedge clk);
      check("orphan_err", 32'(b.tag_err), 32'd1);
      check("orphan_valid", 32'(b.out_valid), 32'd0);
      cyc();
      @(negedge clk);
      check("orphan_sticky", 32'(b.tag_err), 32'd1);
      check("sb_drained", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
